pixel_color_arbiter: RTL

PIXEL_COLOR_ARBITER -- requirements
Module: pixel_color_arbiter

---
 rtl/pixel_color_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pixel_color_arbiter.sv
// Round-robin arbiter that funnels iteration results through a shared color mapper
// into a small write buffer that drains to the framebuffer, counting pixels per frame.
module pixel_color_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 19,
  parameter int NUM_PIXELS = 307200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*32-1:0]     req_iter,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [31:0]               cm_iter,
  input  logic [7:0]                cm_r,
  input  logic [7:0]                cm_g,
  input  logic [7:0]                cm_b,
  output logic                      fb_we,
  output logic [ADDR_W-1:0]         fb_addr,
  output logic [23:0]               fb_data,
  input  logic                      fb_ready,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W   = $clog2(NUM_PIXELS + 1);
  localparam int FA_W    = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = ADDR_W + 24;
  localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(NUM_PIXELS);
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t               r_state;
  logic [PTR_W-1:0]     r_ptr;
  logic [CNT_W-1:0]     r_grant_cnt;
  logic [CNT_W-1:0]     r_wr_cnt;
  logic [31:0]          r_cm_iter;
  logic                 r_s1_valid;
  logic                 r_s2_valid;
  logic [ADDR_W-1:0]    r_s1_addr;
  logic [ADDR_W-1:0]    r_s2_addr;
  logic [ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
  logic [FA_W-1:0]      r_wptr;
  logic [FA_W-1:0]      r_rptr;
  logic [OCC_W-1:0]     r_count;

  logic [31:0]          w_iter [NUM_REQ];
  logic [ADDR_W-1:0]    w_addr [NUM_REQ];
  logic                 w_found;
  logic [PTR_W-1:0]     w_grant_idx;
  logic [OCC_W:0]       w_reserved;
  logic                 w_credit;
  logic                 w_xfer;
  logic                 w_push;
  logic                 w_pop;
  logic [ENTRY_W-1:0]   w_head;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_iter[gi] = req_iter[32*gi +: 32];
    assign w_addr[gi] = req_addr[ADDR_W*gi +: ADDR_W];
  end

  // First valid requester scanning upward from r_ptr, wrapping around.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found     = 1'b1;
        w_grant_idx = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Items still in the mapper pipeline count against buffer space, so a push never finds it full.
  assign w_reserved = (OCC_W+1)'(r_count) + (OCC_W+1)'(r_s1_valid) + (OCC_W+1)'(r_s2_valid);
  assign w_credit   = w_reserved < (OCC_W+1)'(FIFO_DEPTH);
  assign w_xfer     = (r_state == ST_RUN) && (r_grant_cnt < PIX_TOTAL) && w_credit && w_found;
  assign req_ready  = w_xfer ? (NUM_REQ'(1) << w_grant_idx) : '0;

  assign w_push     = r_s2_valid;
  assign fb_we      = (r_count != '0);
  assign w_pop      = fb_we && fb_ready;
  assign w_head     = r_mem[r_rptr];
  assign fb_addr    = fb_we ? w_head[ENTRY_W-1:24] : '0;
  assign fb_data    = fb_we ? w_head[23:0] : '0;

  assign cm_iter    = r_cm_iter;
  assign busy       = (r_state == ST_RUN);
  assign frame_done = (r_state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wptr] <= {r_s2_addr, cm_r, cm_g, cm_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_grant_cnt <= '0;
      r_wr_cnt    <= '0;
      r_cm_iter   <= '0;
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s1_addr   <= '0;
      r_s2_addr   <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_RUN;
            r_grant_cnt <= '0;
            r_wr_cnt    <= '0;
          end
        end
        ST_RUN: begin
          if (w_pop && r_wr_cnt == PIX_LAST) begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_xfer) begin
        r_ptr       <= (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
        r_cm_iter   <= w_iter[w_grant_idx];
        r_s1_addr   <= w_addr[w_grant_idx];
        r_grant_cnt <= r_grant_cnt + 1'b1;
      end
      r_s1_valid <= w_xfer;
      r_s2_valid <= r_s1_valid;
      r_s2_addr  <= r_s1_addr;

      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr   <= r_rptr + 1'b1;
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule
